// File: rtl/varredor_bitmap_pkg.sv
// varredor_pkg: shared types and constants for the bitmap scanner.
// FSM state encoding, default parameter values and the saturating alarm counter.
package varredor_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONSULTA = 2'd1,
    ESPERA   = 2'd2
  } estado_t;

  localparam int NUM_CLUSTERS_DEF  = 8;
  localparam int TAM_ENDERECO_DEF  = 2;
  localparam int TAM_HASH_DOIS_DEF = 8;
  localparam int TIMEOUT_DEF       = 64;

  localparam int                CONT_W   = 16;
  localparam logic [CONT_W-1:0] CONT_SAT = '1;

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
    return (v == CONT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/varredor_bitmap_if.sv
// varredor_bitmap_if: lookup channel between the scanner and the cluster table.
// Request is valid/ready; the response is a single-cycle strobe with a hit flag.
interface varredor_bitmap_if
  import varredor_pkg::*;
#(
  parameter int NUM_CLUSTERS  = NUM_CLUSTERS_DEF,
  parameter int TAM_ENDERECO  = TAM_ENDERECO_DEF,
  parameter int TAM_HASH_DOIS = TAM_HASH_DOIS_DEF
);
  localparam int IDX_W = $clog2(NUM_CLUSTERS);

  logic                     consulta_valida;
  logic                     consulta_pronta;
  logic [IDX_W-1:0]         consulta_cluster;
  logic [TAM_ENDERECO-1:0]  consulta_endereco;
  logic [TAM_HASH_DOIS-1:0] consulta_hash;
  logic                     resposta_valida;
  logic                     resposta_acerto;

  // Scanner side: issues requests, receives responses.
  modport master (
    output consulta_valida, consulta_cluster, consulta_endereco, consulta_hash,
    input  consulta_pronta, resposta_valida, resposta_acerto
  );

  // Cluster table side.
  modport slave (
    input  consulta_valida, consulta_cluster, consulta_endereco, consulta_hash,
    output consulta_pronta, resposta_valida, resposta_acerto
  );

endinterface

// File: rtl/varredor_bitmap_primeiro_bit.sv
// primeiro_bit: lowest-set-bit priority encoder.
// Returns the index of the least significant 1 and a nonzero flag.
module primeiro_bit #(
  parameter int W = 8
) (
  input  logic [W-1:0]         vetor,
  output logic [$clog2(W)-1:0] indice,
  output logic                 nao_zero
);
  localparam int IW = $clog2(W);

  // Scan from MSB down so the last hit written is the lowest set bit.
  always_comb begin
    indice   = '0;
    nao_zero = |vetor;
    for (int i = W - 1; i >= 0; i--) begin
      if (vetor[i]) indice = IW'(i);
    end
  end

endmodule

// File: rtl/varredor_bitmap.sv
// varredor_bitmap: consumer for the head of the candidate buffer.
// Walks the head bitmap LSB first, one lookup per set bit, and drives the
// buffer write-back/removal controls. Confirmed hits raise a registered alarm.
// Optional response watchdog: define VARREDOR_TIMEOUT_EN.
module varredor_bitmap
  import varredor_pkg::*;
#(
  parameter int NUM_CLUSTERS  = NUM_CLUSTERS_DEF,
  parameter int TAM_ENDERECO  = TAM_ENDERECO_DEF,
  parameter int TAM_HASH_DOIS = TAM_HASH_DOIS_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            saida_valida,
  input  logic [NUM_CLUSTERS-1:0]         bitmap_atual,
  input  logic [TAM_ENDERECO-1:0]         endereco_atual,
  input  logic [TAM_HASH_DOIS-1:0]        hash_atual,
  output logic [NUM_CLUSTERS-1:0]         bitmap_atualizado,
  output logic                            zero,
  output logic                            suspeito,
  varredor_bitmap_if.master               consulta,
  output logic                            alarme_valido,
  output logic [TAM_ENDERECO-1:0]         alarme_endereco,
  output logic [$clog2(NUM_CLUSTERS)-1:0] alarme_cluster,
  output logic [CONT_W-1:0]               contador_alarmes,
  output logic                            erro_timeout
);
  localparam int IDX_W = $clog2(NUM_CLUSTERS);

  estado_t                  estado_q, estado_d;
  logic                     consulta_valida_q, consulta_valida_d;
  logic [IDX_W-1:0]         cluster_q, cluster_d;
  logic [TAM_ENDERECO-1:0]  endereco_q, endereco_d;
  logic [TAM_HASH_DOIS-1:0] hash_q, hash_d;
  logic                     alarme_valido_q, alarme_valido_d;
  logic [TAM_ENDERECO-1:0]  alarme_endereco_q, alarme_endereco_d;
  logic [IDX_W-1:0]         alarme_cluster_q, alarme_cluster_d;
  logic [CONT_W-1:0]        contador_q, contador_d;

  logic [IDX_W-1:0]         idx_baixo;
  logic                     tem_bit;
  logic                     estouro;
  logic                     acerto_ev;
  logic                     falha_ev;
  logic [NUM_CLUSTERS-1:0]  bitmap_limpo;

  primeiro_bit #(.W(NUM_CLUSTERS)) u_primeiro_bit (
    .vetor    (bitmap_atual),
    .indice   (idx_baixo),
    .nao_zero (tem_bit)
  );

`ifdef VARREDOR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             erro_q, erro_d;

  // Watchdog: counts ESPERA cycles without a response; on the last one the
  // lookup is forced to a miss and the error pulse is registered.
  always_comb begin
    tmr_d   = '0;
    estouro = 1'b0;
    if (estado_q == ESPERA && !consulta.resposta_valida) begin
      if (tmr_q == TMR_W'(TIMEOUT - 1)) estouro = 1'b1;
      else                              tmr_d   = tmr_q + 1'b1;
    end
    erro_d = estouro;
  end

  // Watchdog state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q  <= '0;
      erro_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      erro_q <= erro_d;
    end
  end

  assign erro_timeout = erro_q;
`else
  assign estouro      = 1'b0;
  assign erro_timeout = 1'b0;
`endif

  // Response outcome; responses outside ESPERA never reach these.
  assign acerto_ev    = (estado_q == ESPERA) && consulta.resposta_valida && consulta.resposta_acerto;
  assign falha_ev     = ((estado_q == ESPERA) && consulta.resposta_valida && !consulta.resposta_acerto)
                        || estouro;
  assign bitmap_limpo = bitmap_atual & ~(NUM_CLUSTERS'(1) << cluster_q);

  // Buffer controls: write-back is a no-op except on a miss; removal only
  // ever requested while the head is valid, and hit/miss are exclusive.
  always_comb begin
    bitmap_atualizado = falha_ev ? bitmap_limpo : bitmap_atual;
    suspeito          = saida_valida && acerto_ev;
    zero              = saida_valida &&
                        (((estado_q == OCIOSO) && !tem_bit) ||
                         (falha_ev && (bitmap_limpo == '0)));
  end

  // Scanner FSM next state and registered outputs.
  always_comb begin
    estado_d          = estado_q;
    consulta_valida_d = consulta_valida_q;
    cluster_d         = cluster_q;
    endereco_d        = endereco_q;
    hash_d            = hash_q;
    alarme_valido_d   = 1'b0;
    alarme_endereco_d = alarme_endereco_q;
    alarme_cluster_d  = alarme_cluster_q;
    contador_d        = contador_q;
    unique case (estado_q)
      OCIOSO: begin
        if (saida_valida && tem_bit) begin
          cluster_d         = idx_baixo;
          endereco_d        = endereco_atual;
          hash_d            = hash_atual;
          consulta_valida_d = 1'b1;
          estado_d          = CONSULTA;
        end
      end
      CONSULTA: begin
        if (consulta.consulta_pronta) begin
          consulta_valida_d = 1'b0;
          estado_d          = ESPERA;
        end
      end
      ESPERA: begin
        if (acerto_ev) begin
          alarme_valido_d   = 1'b1;
          alarme_endereco_d = endereco_q;
          alarme_cluster_d  = cluster_q;
          contador_d        = sat_inc(contador_q);
          estado_d          = OCIOSO;
        end else if (falha_ev) begin
          estado_d          = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // FSM and output registers; reset drops any in-flight lookup.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q          <= OCIOSO;
      consulta_valida_q <= 1'b0;
      cluster_q         <= '0;
      endereco_q        <= '0;
      hash_q            <= '0;
      alarme_valido_q   <= 1'b0;
      alarme_endereco_q <= '0;
      alarme_cluster_q  <= '0;
      contador_q        <= '0;
    end else begin
      estado_q          <= estado_d;
      consulta_valida_q <= consulta_valida_d;
      cluster_q         <= cluster_d;
      endereco_q        <= endereco_d;
      hash_q            <= hash_d;
      alarme_valido_q   <= alarme_valido_d;
      alarme_endereco_q <= alarme_endereco_d;
      alarme_cluster_q  <= alarme_cluster_d;
      contador_q        <= contador_d;
    end
  end

  assign consulta.consulta_valida   = consulta_valida_q;
  assign consulta.consulta_cluster  = cluster_q;
  assign consulta.consulta_endereco = endereco_q;
  assign consulta.consulta_hash     = hash_q;
  assign alarme_valido              = alarme_valido_q;
  assign alarme_endereco            = alarme_endereco_q;
  assign alarme_cluster             = alarme_cluster_q;
  assign contador_alarmes           = contador_q;

endmodule

// File: tb/tb_varredor_bitmap.sv
// tb_varredor_bitmap: scoreboard bench for varredor_bitmap.
// Expected requests/alarms are queued when a head is presented and popped by
// monitors when the DUT issues them. VARREDOR_TIMEOUT_EN selects the watchdog test.
module tb_varredor_bitmap;
  localparam int NC = 8;
  localparam int TE = 2;
  localparam int TH = 8;
  localparam int TO = 4;

  typedef struct {
    logic [2:0] cl;
    logic [1:0] ad;
    logic [7:0] h;
  } req_t;

  typedef struct {
    logic [1:0] ad;
    logic [2:0] cl;
  } alm_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          saida_valida;
  logic [NC-1:0] bitmap_atual;
  logic [TE-1:0] endereco_atual;
  logic [TH-1:0] hash_atual;
  logic [NC-1:0] bitmap_atualizado;
  logic          zero, suspeito;
  logic          alarme_valido;
  logic [TE-1:0] alarme_endereco;
  logic [2:0]    alarme_cluster;
  logic [15:0]   contador_alarmes;
  logic          erro_timeout;

  int tests = 0;
  int fails = 0;
  req_t exp_req[$];
  alm_t exp_alm[$];

  varredor_bitmap_if #(.NUM_CLUSTERS(NC), .TAM_ENDERECO(TE), .TAM_HASH_DOIS(TH)) cif ();

  varredor_bitmap #(.NUM_CLUSTERS(NC), .TAM_ENDERECO(TE), .TAM_HASH_DOIS(TH), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .saida_valida      (saida_valida),
    .bitmap_atual      (bitmap_atual),
    .endereco_atual    (endereco_atual),
    .hash_atual        (hash_atual),
    .bitmap_atualizado (bitmap_atualizado),
    .zero              (zero),
    .suspeito          (suspeito),
    .consulta          (cif),
    .alarme_valido     (alarme_valido),
    .alarme_endereco   (alarme_endereco),
    .alarme_cluster    (alarme_cluster),
    .contador_alarmes  (contador_alarmes),
    .erro_timeout      (erro_timeout)
  );

  always #5 clk = ~clk;

  // Request scoreboard: every accepted request must match the queue head.
  always @(negedge clk) begin : mon_req
    req_t r;
    if (reset && cif.consulta_valida && cif.consulta_pronta) begin
      tests++;
      if (exp_req.size() == 0) begin
        fails++;
        $display("FAIL unexpected_request got cl=%0d ad=%0d h=%h, none expected",
                 cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash);
      end else begin
        r = exp_req.pop_front();
        if ({cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash} !== {r.cl, r.ad, r.h}) begin
          fails++;
          $display("FAIL request got cl=%0d ad=%0d h=%h want cl=%0d ad=%0d h=%h",
                   cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash, r.cl, r.ad, r.h);
        end
      end
    end
  end

  // Alarm scoreboard.
  always @(negedge clk) begin : mon_alm
    alm_t a;
    if (reset && alarme_valido) begin
      tests++;
      if (exp_alm.size() == 0) begin
        fails++;
        $display("FAIL unexpected_alarm got ad=%0d cl=%0d", alarme_endereco, alarme_cluster);
      end else begin
        a = exp_alm.pop_front();
        if ({alarme_endereco, alarme_cluster} !== {a.ad, a.cl}) begin
          fails++;
          $display("FAIL alarm got ad=%0d cl=%0d want ad=%0d cl=%0d",
                   alarme_endereco, alarme_cluster, a.ad, a.cl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a request handshake; returns just after the edge that enters ESPERA.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cif.consulta_valida && cif.consulta_pronta) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) tick();
  endtask

  task automatic head(input logic [NC-1:0] b, input logic [TE-1:0] a, input logic [TH-1:0] h);
    saida_valida   = 1'b1;
    bitmap_atual   = b;
    endereco_atual = a;
    hash_atual     = h;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0; endereco_atual = '0; hash_atual = '0;
    cif.consulta_pronta = 1'b0; cif.resposta_valida = 1'b0; cif.resposta_acerto = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    tests++;
    if ({cif.consulta_valida, cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash} !== 14'd0) begin
      fails++; $display("FAIL reset_consulta got %b want 0",
                        {cif.consulta_valida, cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash});
    end
    tests++;
    if ({alarme_valido, alarme_endereco, alarme_cluster, contador_alarmes, erro_timeout} !== 23'd0) begin
      fails++; $display("FAIL reset_alarme got %b want 0",
                        {alarme_valido, alarme_endereco, alarme_cluster, contador_alarmes, erro_timeout});
    end
    tests++;
    if ({zero, suspeito} !== 2'b00) begin
      fails++; $display("FAIL reset_removal got %b want 00", {zero, suspeito});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    head(8'b0000_0000, 2'd1, 8'h11);
    @(negedge clk);
    tests++;
    if ({zero, suspeito} !== 2'b10) begin
      fails++; $display("FAIL zero_empty got zero/suspeito=%b want 10", {zero, suspeito});
    end
    tick();
    saida_valida = 1'b0;
    @(negedge clk);
    tests++;
    if ({cif.consulta_valida, zero} !== 2'b00) begin
      fails++; $display("FAIL zero_no_request got valida/zero=%b want 00", {cif.consulta_valida, zero});
    end
    tick();
  endtask

  task automatic test_miss_miss();
    bit ok;
    cif.consulta_pronta = 1'b1;
    head(8'b0010_0100, 2'd2, 8'hA5);
    exp_req.push_back('{3'd2, 2'd2, 8'hA5});
    exp_req.push_back('{3'd5, 2'd2, 8'hA5});
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL miss1_timeout got no request want cluster 2"); end
    cif.resposta_valida = 1'b1; cif.resposta_acerto = 1'b0;
    @(negedge clk);
    tests++;
    if ({bitmap_atualizado, zero, suspeito} !== {8'b0010_0000, 2'b00}) begin
      fails++; $display("FAIL miss1_writeback got %b z=%b s=%b want 00100000 z=0 s=0",
                        bitmap_atualizado, zero, suspeito);
    end
    tick();
    cif.resposta_valida = 1'b0;
    bitmap_atual = 8'b0010_0000;
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL miss2_timeout got no request want cluster 5"); end
    cif.resposta_valida = 1'b1;
    @(negedge clk);
    tests++;
    if ({bitmap_atualizado, zero, suspeito} !== {8'b0000_0000, 2'b10}) begin
      fails++; $display("FAIL miss2_zero got %b z=%b s=%b want 00000000 z=1 s=0",
                        bitmap_atualizado, zero, suspeito);
    end
    tick();
    cif.resposta_valida = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0;
    tick();
  endtask

  task automatic test_hit();
    bit ok;
    head(8'b1000_0001, 2'd1, 8'h3C);
    exp_req.push_back('{3'd0, 2'd1, 8'h3C});
    exp_alm.push_back('{2'd1, 3'd0});
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hit_timeout got no request want cluster 0"); end
    cif.resposta_valida = 1'b1; cif.resposta_acerto = 1'b1;
    @(negedge clk);
    tests++;
    if ({suspeito, zero, alarme_valido, bitmap_atualizado} !== {3'b100, 8'b1000_0001}) begin
      fails++; $display("FAIL hit_suspeito got s=%b z=%b a=%b bm=%b want s=1 z=0 a=0 bm=10000001",
                        suspeito, zero, alarme_valido, bitmap_atualizado);
    end
    tick();
    cif.resposta_valida = 1'b0; cif.resposta_acerto = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0;
    @(negedge clk);
    tests++;
    if ({alarme_valido, contador_alarmes} !== {1'b1, 16'd1}) begin
      fails++; $display("FAIL hit_alarm got a=%b cnt=%0d want a=1 cnt=1", alarme_valido, contador_alarmes);
    end
    tick();
    @(negedge clk);
    tests++;
    if (alarme_valido !== 1'b0) begin
      fails++; $display("FAIL hit_pulse got alarme_valido=%b want 0", alarme_valido);
    end
    repeat (3) tick();
  endtask

  task automatic test_stall();
    bit ok;
    cif.consulta_pronta = 1'b0;
    head(8'b0000_1000, 2'd3, 8'hC3);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({cif.consulta_valida, cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash, zero, suspeito}
          !== {1'b1, 3'd3, 2'd3, 8'hC3, 2'b00}) begin
        fails++; $display("FAIL stall_hold cycle %0d got v=%b cl=%0d ad=%0d h=%h z=%b s=%b want v=1 cl=3 ad=3 h=c3 z=0 s=0",
                          i, cif.consulta_valida, cif.consulta_cluster, cif.consulta_endereco,
                          cif.consulta_hash, zero, suspeito);
      end
      tick();
    end
    exp_req.push_back('{3'd3, 2'd3, 8'hC3});
    cif.consulta_pronta = 1'b1;
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_timeout got no handshake want one"); end
    repeat (2) begin
      @(negedge clk);
      tests++;
      if ({cif.consulta_valida, zero, suspeito, bitmap_atualizado} !== {3'b000, 8'b0000_1000}) begin
        fails++; $display("FAIL espera_idle got v=%b z=%b s=%b bm=%b want 0 0 0 00001000",
                          cif.consulta_valida, zero, suspeito, bitmap_atualizado);
      end
      tick();
    end
    cif.resposta_valida = 1'b1; cif.resposta_acerto = 1'b0;
    @(negedge clk);
    tests++;
    if ({zero, bitmap_atualizado} !== {1'b1, 8'b0}) begin
      fails++; $display("FAIL stall_zero got z=%b bm=%b want z=1 bm=0", zero, bitmap_atualizado);
    end
    tick();
    cif.resposta_valida = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    head(8'b0100_0000, 2'd2, 8'h77);
    exp_req.push_back('{3'd6, 2'd2, 8'h77});
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rstmid_timeout got no request want cluster 6"); end
    reset = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0;
    tick();
    reset = 1'b1;
    cif.resposta_valida = 1'b1; cif.resposta_acerto = 1'b1;
    @(negedge clk);
    tests++;
    if ({suspeito, zero, cif.consulta_valida, cif.consulta_cluster, cif.consulta_endereco, cif.consulta_hash} !== 16'd0) begin
      fails++; $display("FAIL rstmid_outputs got s=%b z=%b v=%b cl=%0d ad=%0d h=%h want all 0",
                        suspeito, zero, cif.consulta_valida, cif.consulta_cluster,
                        cif.consulta_endereco, cif.consulta_hash);
    end
    tick();
    cif.resposta_valida = 1'b0; cif.resposta_acerto = 1'b0;
    @(negedge clk);
    tests++;
    if ({alarme_valido, alarme_endereco, alarme_cluster, contador_alarmes, erro_timeout} !== 23'd0) begin
      fails++; $display("FAIL rstmid_alarm got a=%b ad=%0d cl=%0d cnt=%0d e=%b want all 0",
                        alarme_valido, alarme_endereco, alarme_cluster, contador_alarmes, erro_timeout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    head(8'b0001_0000, 2'd2, 8'h01);
    exp_req.push_back('{3'd4, 2'd2, 8'h01});
    exp_alm.push_back('{2'd2, 3'd4});
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_a_timeout got no request want cluster 4"); end
    cif.resposta_valida = 1'b1; cif.resposta_acerto = 1'b1;
    @(negedge clk);
    tests++;
    if (suspeito !== 1'b1) begin fails++; $display("FAIL b2b_a_suspeito got %b want 1", suspeito); end
    exp_req.push_back('{3'd1, 2'd3, 8'h02});
    exp_alm.push_back('{2'd3, 3'd1});
    tick();
    cif.resposta_valida = 1'b0; cif.resposta_acerto = 1'b0;
    head(8'b0000_0110, 2'd3, 8'h02);
    @(negedge clk);
    tests++;
    if (contador_alarmes !== 16'd1) begin
      fails++; $display("FAIL b2b_cnt1 got %0d want 1", contador_alarmes);
    end
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_b_timeout got no request want cluster 1"); end
    cif.resposta_valida = 1'b1; cif.resposta_acerto = 1'b1;
    @(negedge clk);
    tests++;
    if ({suspeito, zero} !== 2'b10) begin
      fails++; $display("FAIL b2b_b_suspeito got s/z=%b want 10", {suspeito, zero});
    end
    tick();
    cif.resposta_valida = 1'b0; cif.resposta_acerto = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0;
    @(negedge clk);
    tests++;
    if (contador_alarmes !== 16'd2) begin
      fails++; $display("FAIL b2b_cnt2 got %0d want 2", contador_alarmes);
    end
    repeat (2) tick();
  endtask

`ifdef VARREDOR_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    head(8'b0000_0011, 2'd1, 8'h42);
    exp_req.push_back('{3'd0, 2'd1, 8'h42});
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL to_req_timeout got no request want cluster 0"); end
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      tests++;
      if ({bitmap_atualizado, zero, erro_timeout} !== {8'b0000_0011, 2'b00}) begin
        fails++; $display("FAIL to_wait cycle %0d got bm=%b z=%b e=%b want 00000011 0 0",
                          i, bitmap_atualizado, zero, erro_timeout);
      end
      tick();
    end
    @(negedge clk);
    tests++;
    if ({bitmap_atualizado, zero} !== {8'b0000_0010, 1'b0}) begin
      fails++; $display("FAIL to_clear got bm=%b z=%b want 00000010 0", bitmap_atualizado, zero);
    end
    tick();
    saida_valida = 1'b0; bitmap_atual = '0;
    @(negedge clk);
    tests++;
    if (erro_timeout !== 1'b1) begin fails++; $display("FAIL to_pulse got %b want 1", erro_timeout); end
    tick();
    @(negedge clk);
    tests++;
    if (erro_timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_end got %b want 0", erro_timeout); end
    tick();
  endtask
`else
  task automatic test_timeout();
    bit ok;
    head(8'b0000_0001, 2'd0, 8'h10);
    exp_req.push_back('{3'd0, 2'd0, 8'h10});
    wait_req(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL nto_req_timeout got no request want cluster 0"); end
    repeat (10) begin
      @(negedge clk);
      tests++;
      if ({erro_timeout, zero, suspeito, bitmap_atualizado} !== {3'b000, 8'b0000_0001}) begin
        fails++; $display("FAIL nto_wait got e=%b z=%b s=%b bm=%b want 0 0 0 00000001",
                          erro_timeout, zero, suspeito, bitmap_atualizado);
      end
      tick();
    end
    reset = 1'b0;
    saida_valida = 1'b0; bitmap_atual = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_miss_miss();
    test_hit();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    repeat (3) tick();
    tests++;
    if (exp_req.size() != 0) begin
      fails++; $display("FAIL pending_requests got %0d outstanding want 0", exp_req.size());
    end
    tests++;
    if (exp_alm.size() != 0) begin
      fails++; $display("FAIL pending_alarms got %0d outstanding want 0", exp_alm.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
